// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            misaligned;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries; clear has priority over push and pop.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    push_en  = push && !clear && !full;
    pop_en   = pop && !clear && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      // Pointers realign on flush so the head slot is fresh.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_en && !pop_en) count_d = count_q + CW'(1);
      else if (pop_en && !push_en) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_en) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, results buffered for decode.
// state | meaning
// RUN   | no request outstanding
// WAIT  | one request outstanding, response will be buffered
// DRAIN | one request outstanding, response will be dropped (flushed)
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = rv32i_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_stall,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_misaligned
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic          can_issue, pc_aligned, req_fire, mis_push, rsp_push;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  fetch_entry_t  push_entry, head;
  logic [CW-1:0] fifo_count;

  assign pc_aligned     = (pc_in[1:0] == 2'b00);
  assign can_issue      = (state_q == RUN) && rst && !flush && (fifo_count < DEPTH_C);
  assign imem_req_valid = can_issue && pc_aligned;
  assign imem_req_addr  = pc_in;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign mis_push       = can_issue && !pc_aligned;
  assign pc_stall       = !(req_fire || mis_push);

  assign rsp_push  = (state_q == WAIT) && imem_rsp_valid && !flush;
  assign fifo_push = rsp_push || mis_push;
  assign fifo_pop  = if_valid && if_ready;

  always_comb begin
    push_entry = '0;
    if (mis_push) begin
      push_entry.instr      = NOP_INSTR;
      push_entry.pc         = pc_in;
      push_entry.misaligned = 1'b1;
    end else begin
      push_entry.instr      = imem_rsp_data;
      push_entry.pc         = pend_pc_q;
      push_entry.misaligned = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      RUN: begin
        if (req_fire) begin
          state_d   = WAIT;
          pend_pc_d = pc_in;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) state_d = RUN;
        else if (flush)     state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .clear     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Invalidation on reset/flush comes from the registered count alone.
  assign if_valid      = !fifo_empty;
  assign if_instr      = head.instr;
  assign if_pc         = head.pc;
  assign if_misaligned = head.misaligned;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly downstream of the program counter. It takes the current PC, issues at most one outstanding read to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds decode over a valid/ready channel. The unit drives a stall back to PC-update control and discards in-flight fetches on a redirect flush.

## Interface
- `DEPTH`, default 2: fetch buffer entries; power of two, ≥2.
- `XLEN`, default 32: address and instruction width.
- `clk` in 1: rising-edge clock; the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `pc_in` in XLEN: PC to fetch this cycle.
- `pc_stall` out 1: high means `pc_in` was not consumed this cycle, so PC must hold.
- `flush` in 1: redirect (taken branch, JAL, JALR); kills buffered and in-flight fetches.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out XLEN: word address; equals `pc_in`.
- `imem_rsp_valid` in 1: response valid. Exactly one response per accepted request, arriving ≥1 cycle after acceptance.
- `imem_rsp_data` in XLEN: instruction word.
- `if_valid` out 1: buffer head valid.
- `if_ready` in 1: decode accepts the head.
- `if_instr` out XLEN: head instruction.
- `if_pc` out XLEN: PC of the head instruction.
- `if_misaligned` out 1: head came from a PC with `pc[1:0] != 0`.

## Operation
- FSM states:
  - RUN: no request outstanding.
  - WAIT: one request outstanding.
  - DRAIN: one request outstanding whose response is discarded.
- Issue condition `can_issue`: state is RUN, `rst` is deasserted, `flush` is low, and registered `count < DEPTH`.
- `imem_req_valid = can_issue && pc_in[1:0] == 0`.
- On `imem_req_valid && imem_req_ready`: latch `pc_in` as `pend_pc` and go to WAIT.
- Misaligned PC: when `can_issue` and `pc_in[1:0] != 0`, no memory request is made. Instead, push {NOP `0x00000013`, `pc_in`, misaligned=1} directly and stay in RUN.
- `pc_stall` is low only in a cycle where a request is accepted or a misaligned entry is pushed. It is high in every other cycle, including during reset.
- In WAIT, on `imem_rsp_valid`: push {`imem_rsp_data`, `pend_pc`, 0} and go to RUN. No new request is issued in the same cycle.
- Credit rule: `count` plus outstanding requests never exceeds `DEPTH`, so a response always has a free slot.
- Pop happens on `if_valid && if_ready`. Push and pop may occur in the same cycle; `count` is then unchanged.
- `flush` has priority over everything else in its cycle:
  - `count` is zeroed and the head is invalidated.
  - Any pop or push in that cycle is ignored.
  - The state moves: WAIT → DRAIN (or → RUN if `imem_rsp_valid` is high that same cycle); RUN → RUN; DRAIN → DRAIN (or → RUN if the response arrives that cycle).
- In DRAIN, on `imem_rsp_valid`: drop the data and go to RUN.
- Pointers wrap modulo `DEPTH`.

## Timing
- Reset values, asynchronous on `rst` low:
  - state is RUN; `count`, pointers and `pend_pc` are 0.
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `if_misaligned` = 0.
  - `imem_req_valid` = 0; `pc_stall` = 1.
- Request channel is combinational from `pc_in`: zero-cycle issue.
- Instruction latency: `if_valid` rises the cycle after the `imem_rsp_valid` edge. Best case is PC to `if_valid` in 2 cycles with a 1-cycle memory.
- Throughput with a 1-cycle memory is one instruction per 2 cycles.
- Resetting mid-WAIT abandons the request. The memory system is reset by the same `rst`.
- Output fields are stable while `if_valid && !if_ready`.
- `imem_req_addr` follows `pc_in`; the PC holds it stable because `pc_stall` is high while `imem_req_ready` is low.

## Structure
- `rv32i_pkg` holds:
  - `XLEN`
  - `NOP_INSTR = 32'h00000013`
  - the `fetch_state_t` enum (RUN, WAIT, DRAIN)
  - the `fetch_entry_t` struct {instr, pc, misaligned}
- Sub-module `fetch_fifo`: parameterised `DEPTH` circular buffer of `fetch_entry_t` with push, pop, clear (flush), count, full and empty. It uses the same asynchronous active-low `rst`.

## Test plan
- Basic fetch: `rst` deasserted, `pc_in` = 0, `imem_req_ready` = 1, response 1 cycle later with `0x00500093` → `if_valid` = 1 the next cycle with `if_instr` = `0x00500093`, `if_pc` = 0, `if_misaligned` = 0; `pc_stall` low in the issue cycle only.
- Backpressure: `if_ready` = 0, fetch PCs 0 and 4 → `count` = 2 and `pc_stall` stuck at 1 with no request. One pop → exactly one new request the following cycle.
- Flush in flight: request PC 8 accepted, `flush` the next cycle, response `0xDEADBEEF` 2 cycles later → it never appears on `if_*`; state goes DRAIN → RUN and the next PC 0x40 fetches normally.
- Misaligned PC: `pc_in` = `0x00000002` → `imem_req_valid` stays 0 and the entry shows {`0x00000013`, `0x2`, misaligned=1} the next cycle.
- Memory stall: `imem_req_ready` low for 3 cycles with `pc_in` = `0x10` → `pc_stall` = 1 and `imem_req_addr` = `0x10` stable for all 3; accepted on the 4th cycle.
- Reset mid-operation: assert `rst` low in WAIT with 1 entry buffered → all outputs return to reset values immediately, without a clock edge.
